// File: rtl/axi4_lite_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite
// register subordinate.
package axi4_lite_pkg;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_e;

    function automatic int f_off_width(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_slave_wr_ctrl.sv
// AW/W capture, write FSM and B channel; emits a one-cycle commit
// request that the register bank applies.
module axi4_lite_slave_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 8,
    parameter int G_DATA_WIDTH = 32,
    parameter int G_NB_REGS    = 16,
    localparam int OFF_W = f_off_width(G_DATA_WIDTH),
    localparam int IDX_W = G_ADDR_WIDTH - OFF_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      awvalid,
    input  logic [G_ADDR_WIDTH-1:0]   awaddr,
    output logic                      awready,
    input  logic                      wvalid,
    input  logic [G_DATA_WIDTH-1:0]   wdata,
    input  logic [G_DATA_WIDTH/8-1:0] wstrb,
    output logic                      wready,
    input  logic                      bready,
    output logic                      bvalid,
    output logic [1:0]                bresp,
    output logic                      commit,
    output logic [IDX_W-1:0]          commit_idx,
    output logic [G_DATA_WIDTH-1:0]   commit_data,
    output logic [G_DATA_WIDTH/8-1:0] commit_strb,
    output logic                      commit_err
);

    wr_state_e                 state;
    logic                      aw_held;
    logic                      w_held;
    logic                      aw_hs;
    logic                      w_hs;
    logic [IDX_W-1:0]          idx_q;
    logic [G_DATA_WIDTH-1:0]   data_q;
    logic [G_DATA_WIDTH/8-1:0] strb_q;
    logic                      unused_ok;

    assign unused_ok = ^awaddr[OFF_W-1:0];

    assign awready = !aw_held && !bvalid;
    assign wready  = !w_held && !bvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    assign commit      = (state == W_COMMIT);
    assign commit_idx  = idx_q;
    assign commit_data = data_q;
    assign commit_strb = strb_q;
    assign commit_err  = 32'(idx_q) >= G_NB_REGS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bvalid  <= 1'b0;
            bresp   <= C_RESP_OKAY;
        end else begin
            unique case (state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        idx_q   <= awaddr[G_ADDR_WIDTH-1:OFF_W];
                    end
                    if (w_hs) begin
                        w_held <= 1'b1;
                        data_q <= wdata;
                        strb_q <= wstrb;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs))
                        state <= W_COMMIT;
                end
                W_COMMIT: begin
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    bvalid  <= 1'b1;
                    bresp   <= commit_err ? C_RESP_SLVERR : C_RESP_OKAY;
                    state   <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite subordinate exposing a bank of read/write registers with
// per-register write pulses.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 8,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_NB_REGS              = 16,
    parameter logic [G_AXI4_LITE_DATA_WIDTH-1:0] G_REG_RESET = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  awvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                            awprot,
    output logic                                  awready,
    input  logic                                  wvalid,
    input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata,
    input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb,
    output logic                                  wready,
    input  logic                                  bready,
    output logic                                  bvalid,
    output logic [1:0]                            bresp,
    input  logic                                  arvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                            arprot,
    output logic                                  arready,
    input  logic                                  rready,
    output logic                                  rvalid,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                            rresp,
    output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0] regs_o,
    output logic [G_NB_REGS-1:0]                  wr_pulse_o
);

    localparam int DW    = G_AXI4_LITE_DATA_WIDTH;
    localparam int AW    = G_AXI4_LITE_ADDR_WIDTH;
    localparam int NBL   = DW / 8;
    localparam int OFF_W = f_off_width(DW);
    localparam int IDX_W = AW - OFF_W;

    logic [DW-1:0]        regs_q [G_NB_REGS];
    logic [G_NB_REGS-1:0] wr_sel;
    logic                 commit;
    logic [IDX_W-1:0]     commit_idx;
    logic [DW-1:0]        commit_data;
    logic [NBL-1:0]       commit_strb;
    logic                 commit_err;
    rd_state_e            r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_err;
    logic [DW-1:0]        rd_word;
    logic                 unused_ok;

    assign unused_ok = ^{awprot, arprot, araddr[OFF_W-1:0]};

    axi4_lite_slave_wr_ctrl #(
        .G_ADDR_WIDTH (AW),
        .G_DATA_WIDTH (DW),
        .G_NB_REGS    (G_NB_REGS)
    ) u_wr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .awready     (awready),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wready      (wready),
        .bready      (bready),
        .bvalid      (bvalid),
        .bresp       (bresp),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .commit_err  (commit_err)
    );

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < G_NB_REGS; i++)
            if (commit && !commit_err && commit_idx == IDX_W'(i))
                wr_sel[i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_NB_REGS; i++)
                regs_q[i] <= G_REG_RESET;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= wr_sel;
            for (int i = 0; i < G_NB_REGS; i++)
                for (int k = 0; k < NBL; k++)
                    if (wr_sel[i] && commit_strb[k])
                        regs_q[i][8*k +: 8] <= commit_data[8*k +: 8];
        end
    end

    for (genvar g = 0; g < G_NB_REGS; g++) begin : g_regs_out
        assign regs_o[g*DW +: DW] = regs_q[g];
    end

    // Read sees pre-commit contents because regs_q updates on the same edge.
    assign r_idx   = araddr[AW-1:OFF_W];
    assign r_err   = 32'(r_idx) >= G_NB_REGS;
    assign arready = !rvalid;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < G_NB_REGS; i++)
            if (r_idx == IDX_W'(i))
                rd_word = regs_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= C_RESP_OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rvalid  <= 1'b1;
                        rdata   <= r_err ? '0 : rd_word;
                        rresp   <= r_err ? C_RESP_SLVERR : C_RESP_OKAY;
                        r_state <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
